life_board_arbiter: RTL
=======================

// Module: life_board_arbiter
// PURPOSE
//  Single-port arbiter/sequencer for the 1-bit Life board RAM (64x32 cells, 2048 x 1 bit).
//  Shares one RAM port among three requesters:
//    - VGA display fetch (read)
//    - generation engine neighbour fetch (read)
//    - init/copy writer (write)
//  Sits between those engines and the RAM macro, so the board needs no dual-port or
//  duplicated storage. Display has priority; engine and writer share the port round-robin.
// PARAMETERS
//  ADDR_W        11  board address width (logWIDTH+logHEIGHT)
//  STARVE_LIMIT  15  consecutive denied cycles before a background requester preempts display (1..255)
// PORTS
//  clk            in   1       system clock (24 MHz)
//  rst_n          in   1       asynchronous reset, active-low
//  disp_req       in   1       display read request
//  disp_addr      in   ADDR_W  display cell index
//  disp_gnt       out  1       display granted this cycle (combinational)
//  eng_req        in   1       engine read request
//  eng_addr       in   ADDR_W  engine cell index
//  eng_gnt        out  1       engine granted this cycle (combinational)
//  wr_req         in   1       writer request
//  wr_addr        in   ADDR_W  writer cell index
//  wr_data        in   1       writer cell value
//  wr_gnt         out  1       writer granted this cycle (combinational)
//  ram_en         out  1       RAM access strobe (registered)
//  ram_we         out  1       RAM write enable (registered)
//  ram_addr       out  ADDR_W  RAM address (registered)
//  ram_wdata      out  1       RAM write data (registered)
//  ram_rdata      in   1       RAM read data, valid 1 cycle after ram_en & !ram_we
//  rd_valid       out  1       read return valid
//  rd_port        out  2       return owner: 0=display, 1=engine
//  rd_data        out  1       return data (ram_rdata passthrough, qualified by rd_valid)
//  disp_miss      out  1       pulse: display request denied by starvation preemption
// BEHAVIOUR
//  - Reset (async, rst_n=0): gnts follow comb rules with reqs.
//    ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, rd_valid=0, rd_port=0, disp_miss=0.
//    RR pointer = engine-first; starve counter = 0. Reset mid-transfer drops in-flight returns; no rd_valid after reset.
//  - At most one gnt per cycle. A request is accepted on the edge where req & gnt.
//    req/addr/data must stay stable until granted; a requester may withdraw req before gnt.
//  - Priority:
//    - Display wins whenever disp_req=1, except in a starvation cycle.
//    - Otherwise engine vs writer is round-robin. RR pointer flips only when one of the two is granted.
//  - Starvation:
//    - Counter increments each cycle (eng_req|wr_req) is denied and resets to 0 on any eng/wr grant; it saturates.
//    - When counter==STARVE_LIMIT and disp_req=1: the RR winner is granted, disp_gnt=0, disp_miss=1 for that cycle.
//  - Latency: grant in cycle N.
//    - Cycle N+1: ram_en=1, ram_addr/ram_we/ram_wdata from the granted port.
//    - Cycle N+2 (reads only): rd_valid=1 with rd_port tag; rd_data=ram_rdata.
//    - Back-to-back grants give one access per cycle, zero bubbles.
//  - Writes produce no rd_valid. A read issued the cycle after a write to the same address returns the new value (RAM ordering).
//  - Idle cycle (no req): ram_en=0; ram_addr/ram_wdata hold their previous value.
//  - Address arithmetic: addresses pass through unmodified; wrap is the requesters' responsibility.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stat_disp_miss[15:0], stat_eng_gnt[15:0], stat_wr_gnt[15:0].
//    - Saturating counters, cleared by rst_n.
//    - stat_disp_miss increments with disp_miss; stat_eng_gnt/stat_wr_gnt increment per grant.
//  ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - Reset: hold rst_n=0 with all reqs=1 -> ram_en=0, rd_valid=0; release -> first grant disp_gnt=1.
//  - Read latency: disp_req, addr=0x041, RAM holds 1 -> cycle N+1 ram_en=1, ram_addr=0x041, ram_we=0;
//    N+2 rd_valid=1, rd_port=0, rd_data=1.
//  - Round-robin: eng_req=wr_req=1 for 4 cycles, disp_req=0 -> grants E,W,E,W;
//    ram_we pattern 0,1,0,1 one cycle later.
//  - Starvation: disp_req=1 continuously, eng_req=1 ->
//    eng_gnt=1 and disp_miss=1 exactly on the 16th cycle, then display resumes.
//  - Withdrawal/RAW: wr_req addr=0x7FF data=1 granted, next cycle eng_req addr=0x7FF ->
//    rd_data=1 at rd_valid, rd_port=1.
//  - Reset mid-op: assert rst_n=0 between grant and return -> rd_valid stays 0; with ARB_STATS_EN, all stats read 0.

Source files
------------

// File: rtl/life_board_arbiter.sv
// Single-port arbiter for the 1-bit Life board RAM: display read has priority, engine and writer share round-robin.
// Optional build macro ARB_STATS_EN adds saturating grant/miss statistics outputs.
module life_board_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  input  logic              eng_req,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic              eng_gnt,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_gnt,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  input  logic              ram_rdata,
  output logic              rd_valid,
  output logic [1:0]        rd_port,
  output logic              rd_data,
  output logic              disp_miss
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_disp_miss,
  output logic [15:0]       stat_eng_gnt,
  output logic [15:0]       stat_wr_gnt
`endif
);

  typedef enum logic [1:0] {
    PORT_DISP = 2'd0,
    PORT_ENG  = 2'd1
  } port_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic       rr_wr_first;
  logic [7:0] starve_cnt;
  logic       bg_req;
  logic       starve;
  logic       eng_wins;
  logic       wr_wins;
  port_e      ram_port;

  assign bg_req   = eng_req | wr_req;
  assign eng_wins = eng_req & (~wr_req | ~rr_wr_first);
  assign wr_wins  = wr_req  & (~eng_req | rr_wr_first);
  // A starvation cycle needs a background requester to hand the port to.
  assign starve   = disp_req & bg_req & (starve_cnt == LIMIT);

  assign disp_gnt  = disp_req & ~starve;
  assign eng_gnt   = ~disp_gnt & eng_wins;
  assign wr_gnt    = ~disp_gnt & wr_wins;
  assign disp_miss = starve;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_wr_first <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      if (eng_gnt || wr_gnt) begin
        starve_cnt <= '0;
      end else if (bg_req && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
      if (eng_gnt) begin
        rr_wr_first <= 1'b1;
      end else if (wr_gnt) begin
        rr_wr_first <= 1'b0;
      end
    end
  end

  // Address and write data hold their last value on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 1'b0;
      ram_port  <= PORT_DISP;
    end else begin
      ram_en <= disp_gnt | eng_gnt | wr_gnt;
      ram_we <= wr_gnt;
      if (disp_gnt) begin
        ram_addr <= disp_addr;
        ram_port <= PORT_DISP;
      end else if (eng_gnt) begin
        ram_addr <= eng_addr;
        ram_port <= PORT_ENG;
      end else if (wr_gnt) begin
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_port  <= PORT_DISP;
    end else begin
      rd_valid <= ram_en & ~ram_we;
      rd_port  <= ram_port;
    end
  end

  assign rd_data = rd_valid & ram_rdata;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_disp_miss <= '0;
      stat_eng_gnt   <= '0;
      stat_wr_gnt    <= '0;
    end else begin
      if (disp_miss && stat_disp_miss != 16'hFFFF) stat_disp_miss <= stat_disp_miss + 16'd1;
      if (eng_gnt && stat_eng_gnt != 16'hFFFF)     stat_eng_gnt   <= stat_eng_gnt + 16'd1;
      if (wr_gnt && stat_wr_gnt != 16'hFFFF)       stat_wr_gnt    <= stat_wr_gnt + 16'd1;
    end
  end
`endif

endmodule
